pipe_hazard_scoreboard: RTL and testbench

//  Parametrised hazard scoreboard for the in-order pipeline; replaces the per-source stall-only hazard detection units.

---
 rtl/pipe_hazard_scoreboard_pkg.sv | 18 +
 rtl/pipe_hazard_scoreboard_match.sv | 38 +++
 rtl/pipe_hazard_scoreboard.sv | 93 +++++++++
 tb/tb_pipe_hazard_scoreboard.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_scoreboard_pkg.sv
// Shared types and constants for the in-order pipeline hazard scoreboard.
// Entries carry a fixed-width rd field wide enough for any supported REG_W.
package pipe_pkg;

    localparam int unsigned SB_RD_W = 16;
    localparam int unsigned FWD_RF  = 0;

    localparam int unsigned STG_EX  = 0;
    localparam int unsigned STG_MEM = 1;
    localparam int unsigned STG_WB  = 2;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               load;
    } sb_entry_t;

endpackage

// File: rtl/pipe_hazard_scoreboard_match.sv
// Per-source hazard lookup: finds the youngest in-flight writer of one source
// register among the first CHECK tracked stages.
module hazard_match
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned REG_W = 5,
    parameter int unsigned CHECK = 2,
    parameter int unsigned KW    = 2
)(
    input  logic                  i_src_en,
    input  logic [REG_W-1:0]      i_src_id,
    input  sb_entry_t [DEPTH-1:0] i_entries,
    output logic                  o_hit,
    output logic [KW-1:0]         o_k,
    output logic                  o_is_load
);

    logic [SB_RD_W-1:0] w_id;

    assign w_id = SB_RD_W'(i_src_id);

    always_comb begin
        o_hit     = 1'b0;
        o_k       = '0;
        o_is_load = 1'b0;
        // Scan oldest to youngest so the youngest match overwrites older ones.
        for (int unsigned j = 0; j < DEPTH; j++) begin
            if ((DEPTH - 1 - j) < CHECK && i_src_en && (i_src_id != '0) &&
                i_entries[DEPTH-1-j].valid && (i_entries[DEPTH-1-j].rd == w_id)) begin
                o_hit     = 1'b1;
                o_k       = KW'(DEPTH - 1 - j);
                o_is_load = i_entries[DEPTH-1-j].load;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Hazard scoreboard beside ID: tracks in-flight writers over DEPTH stages and
// produces per-source forwarding selects plus a single pipeline stall.
module pipe_hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned DEPTH      = STG_WB + 1,
    parameter int unsigned REG_W      = 5,
    parameter int unsigned FORWARDING = 1,
    parameter int unsigned LOAD_READY = STG_MEM,
    parameter int unsigned RF_BYPASS  = 1
)(
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_SRC-1:0]                    src_en,
    input  logic [NUM_SRC*REG_W-1:0]              src_id,
    input  logic                                  issue_valid,
    input  logic                                  issue_wb,
    input  logic                                  issue_load,
    input  logic [REG_W-1:0]                      issue_rd,
    input  logic                                  flush,
    output logic                                  stall,
    output logic [NUM_SRC*$clog2(DEPTH+1)-1:0]    fwd_sel,
    output logic [31:0]                           stall_count
);

    localparam int unsigned FWD_W = $clog2(DEPTH + 1);
    localparam int unsigned CHECK = DEPTH - RF_BYPASS;

    sb_entry_t [DEPTH-1:0] r_entries;
    logic [31:0]           r_stall_count;
    sb_entry_t             w_new;
    logic [NUM_SRC-1:0]    w_hit;
    logic [NUM_SRC-1:0]    w_is_load;
    logic [NUM_SRC-1:0]    w_src_stall;
    logic                  w_stall;

    always_comb begin
        w_new = '0;
        if (!w_stall && !flush) begin
            w_new.valid = issue_valid && issue_wb && (issue_rd != '0);
            w_new.rd    = SB_RD_W'(issue_rd);
            w_new.load  = issue_load;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_entries     <= '0;
            r_stall_count <= '0;
        end else begin
            r_entries[STG_EX] <= w_new;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                r_entries[k] <= r_entries[k-1];
            end
            if (w_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [FWD_W-1:0] w_k;

        hazard_match #(
            .DEPTH (DEPTH),
            .REG_W (REG_W),
            .CHECK (CHECK),
            .KW    (FWD_W)
        ) u_match (
            .i_src_en  (src_en[i]),
            .i_src_id  (src_id[i*REG_W +: REG_W]),
            .i_entries (r_entries),
            .o_hit     (w_hit[i]),
            .o_k       (w_k),
            .o_is_load (w_is_load[i])
        );

        if (FORWARDING != 0) begin : g_fwd
            // Only a load whose data is not yet available at its stage blocks issue.
            assign w_src_stall[i] = w_hit[i] && w_is_load[i] && (32'(w_k) < LOAD_READY);
            assign fwd_sel[i*FWD_W +: FWD_W] = w_hit[i] ? (w_k + FWD_W'(1)) : FWD_W'(FWD_RF);
        end else begin : g_nofwd
            assign w_src_stall[i] = w_hit[i];
            assign fwd_sel[i*FWD_W +: FWD_W] = FWD_W'(FWD_RF);
        end
    end

    assign w_stall     = issue_valid && (|w_src_stall);
    assign stall       = w_stall;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Scoreboard bench: a forwarding and a stall-only scoreboard share stimulus;
// expected outputs are queued by the driver and checked by a separate monitor.
module tb_pipe_hazard_scoreboard;

    localparam int unsigned NS = 2;
    localparam int unsigned D  = 3;
    localparam int unsigned RW = 5;
    localparam int unsigned FW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [NS-1:0]     src_en;
    logic [NS*RW-1:0]  src_id;
    logic              issue_valid, issue_wb, issue_load;
    logic [RW-1:0]     issue_rd;
    logic              flush;
    logic              stall_f, stall_s;
    logic [NS*FW-1:0]  fwd_f, fwd_s;
    logic [31:0]       cnt_f, cnt_s;

    pipe_hazard_scoreboard #(.FORWARDING(1)) dut_f (
        .clk(clk), .reset(reset), .src_en(src_en), .src_id(src_id),
        .issue_valid(issue_valid), .issue_wb(issue_wb), .issue_load(issue_load),
        .issue_rd(issue_rd), .flush(flush), .stall(stall_f), .fwd_sel(fwd_f),
        .stall_count(cnt_f)
    );

    pipe_hazard_scoreboard #(.FORWARDING(0)) dut_s (
        .clk(clk), .reset(reset), .src_en(src_en), .src_id(src_id),
        .issue_valid(issue_valid), .issue_wb(issue_wb), .issue_load(issue_load),
        .issue_rd(issue_rd), .flush(flush), .stall(stall_s), .fwd_sel(fwd_s),
        .stall_count(cnt_s)
    );

    // Reference model: list of in-flight writers, index 0 = most recently issued.
    typedef struct { bit v; int unsigned rd; bit ld; } ent_t;
    typedef struct {
        bit st_f; bit [NS*FW-1:0] fw_f; bit [31:0] c_f;
        bit st_s; bit [NS*FW-1:0] fw_s; bit [31:0] c_s;
    } exp_t;

    ent_t        mf[D];
    ent_t        ms[D];
    logic [31:0] cf = '0;
    logic [31:0] cs = '0;
    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc_no = 0;
    bit          started = 1'b0;

    function automatic void predict(input ent_t m[D], input bit fwd_mode,
                                    output bit st, output bit [NS*FW-1:0] fs);
        st = 1'b0;
        fs = '0;
        for (int i = 0; i < NS; i++) begin
            int unsigned r;
            int          young;
            r     = src_id[i*RW +: RW];
            young = -1;
            // WB is write-through, so only EX and MEM writers are hazards.
            if (src_en[i] && r != 0) begin
                for (int k = 0; k < D - 1; k++) begin
                    if (young < 0 && m[k].v && m[k].rd == r) young = k;
                end
            end
            if (young >= 0) begin
                if (fwd_mode) begin
                    fs[i*FW +: FW] = FW'(young + 1);
                    if (m[young].ld && young < 1) st = 1'b1;
                end else begin
                    st = 1'b1;
                end
            end
        end
        st = st && issue_valid;
    endfunction

    task automatic advance(inout ent_t m[D], inout logic [31:0] c, input bit st,
                           input bit rst, input bit v, input bit wb, input bit ld,
                           input int unsigned rd, input bit fl);
        if (rst) begin
            for (int k = 0; k < D; k++) m[k] = '{1'b0, 0, 1'b0};
            c = '0;
        end else begin
            for (int k = D - 1; k > 0; k--) m[k] = m[k-1];
            m[0] = '{(!st && !fl && v && wb && rd != 0), rd, ld};
            if (st && c != 32'hFFFF_FFFF) c = c + 32'd1;
        end
    endtask

    task automatic cyc(input int unsigned rst, input int unsigned v, input int unsigned wb,
                       input int unsigned ld, input int unsigned rd, input int unsigned en,
                       input int unsigned s0, input int unsigned s1, input int unsigned fl);
        exp_t             e;
        bit               sf, ss;
        bit [NS*FW-1:0]   ff, fsx;
        @(negedge clk);
        reset       = (rst != 0);
        issue_valid = (v != 0);
        issue_wb    = (wb != 0);
        issue_load  = (ld != 0);
        issue_rd    = RW'(rd);
        src_en      = NS'(en);
        src_id      = {RW'(s1), RW'(s0)};
        flush       = (fl != 0);
        predict(mf, 1'b1, sf, ff);
        predict(ms, 1'b0, ss, fsx);
        e = '{sf, ff, cf, ss, fsx, cs};
        q.push_back(e);
        started = 1'b1;
        advance(mf, cf, sf, rst != 0, v != 0, wb != 0, ld != 0, rd, fl != 0);
        advance(ms, cs, ss, rst != 0, v != 0, wb != 0, ld != 0, rd, fl != 0);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc_no, act, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle, so one expectation per cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (started) begin
                cyc_no++;
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL queue_empty cycle=%0d actual=0 expected=1", cyc_no);
                end else begin
                    e = q.pop_front();
                    chk("stall_fwd",   32'(stall_f), 32'(e.st_f));
                    chk("fwdsel_fwd",  32'(fwd_f),   32'(e.fw_f));
                    chk("count_fwd",   cnt_f,        e.c_f);
                    chk("stall_nofwd", 32'(stall_s), 32'(e.st_s));
                    chk("fwdsel_nofwd",32'(fwd_s),   32'(e.fw_s));
                    chk("count_nofwd", cnt_s,        e.c_s);
                end
            end
        end
    end

    initial begin : driver
        for (int k = 0; k < D; k++) begin
            mf[k] = '{1'b0, 0, 1'b0};
            ms[k] = '{1'b0, 0, 1'b0};
        end
        reset = 1'b1; issue_valid = 1'b0; issue_wb = 1'b0; issue_load = 1'b0;
        issue_rd = '0; src_en = '0; src_id = '0; flush = 1'b0;
        repeat (3) @(negedge clk);

        idle(1);
        // add x1 ; add x2,x1,x1  -> back-to-back forward from EX
        cyc(0, 1, 1, 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 2, 3, 1, 1, 0);
        cyc(0, 1, 1, 0, 2, 3, 1, 1, 0);
        idle(3);
        // add x1 ; unrelated ; add x2,x1,x1 -> forward from MEM
        cyc(0, 1, 1, 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 4, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 2, 3, 1, 1, 0);
        idle(3);
        // lw x5 ; add x6,x5,x0 held while stalled
        cyc(0, 1, 1, 1, 5, 0, 0, 0, 0);
        repeat (3) cyc(0, 1, 1, 0, 6, 3, 5, 0, 0);
        idle(3);
        // add x1 ; sub x3,x1,x2
        cyc(0, 1, 1, 0, 1, 0, 0, 0, 0);
        repeat (3) cyc(0, 1, 1, 0, 3, 3, 1, 2, 0);
        idle(3);
        // writer to x0, reader of x0; reader with src_en=0 behind a writer
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 4, 3, 0, 0, 0);
        cyc(0, 1, 1, 1, 3, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 4, 0, 3, 3, 0);
        idle(3);
        // addi x3 twice, then reader: youngest writer wins
        cyc(0, 1, 1, 0, 3, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 3, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 5, 1, 3, 0, 0);
        idle(3);
        // lw x7 ; dependent add with reset pulsed in the stall cycle
        cyc(0, 1, 1, 1, 7, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 8, 1, 7, 0, 0);
        cyc(0, 1, 1, 0, 8, 1, 7, 0, 0);
        idle(2);
        // flushed writer leaves no hazard
        cyc(0, 1, 1, 1, 9, 0, 0, 0, 1);
        cyc(0, 1, 1, 0, 10, 3, 9, 9, 0);
        idle(3);

        // Counter saturation: preload both counters just below the maximum.
        @(posedge clk);
        #1;
        force dut_f.r_stall_count = 32'hFFFF_FFFE;
        force dut_s.r_stall_count = 32'hFFFF_FFFE;
        #1;
        release dut_f.r_stall_count;
        release dut_s.r_stall_count;
        cf = 32'hFFFF_FFFE;
        cs = 32'hFFFF_FFFE;
        cyc(0, 1, 1, 1, 7, 0, 0, 0, 0);
        repeat (3) cyc(0, 1, 1, 0, 6, 1, 7, 0, 0);
        cyc(0, 1, 1, 1, 8, 0, 0, 0, 0);
        repeat (3) cyc(0, 1, 1, 0, 6, 2, 0, 8, 0);
        idle(2);

        repeat (1500) begin
            cyc(($urandom_range(0, 63) == 0) ? 1 : 0,
                ($urandom_range(0, 7) != 0) ? 1 : 0,
                ($urandom_range(0, 3) != 0) ? 1 : 0,
                ($urandom_range(0, 2) == 0) ? 1 : 0,
                $urandom_range(0, 7),
                $urandom_range(0, 3),
                $urandom_range(0, 7),
                $urandom_range(0, 7),
                ($urandom_range(0, 9) == 0) ? 1 : 0);
        end

        #4;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_leftover actual=%0d expected=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
